// File: rtl/pac_sprite_drawer.sv
// Draws one 5x5 sprite to a VGA adapter, one pixel per clock, with screen-edge clipping.
// The draw inputs are captured on start, so later input changes do not disturb a draw in progress.
module pac_sprite_drawer #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x_origin,
  input  logic [6:0]  y_origin,
  input  logic [24:0] sprite,
  input  logic [2:0]  colour,
  input  logic        erase,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t      state, state_nxt;
  logic [24:0] cap_sprite;
  logic [7:0]  cap_x;
  logic [6:0]  cap_y;
  logic [2:0]  cap_colour;
  logic        cap_erase;
  logic [2:0]  row, col;

  logic [7:0]  vga_x_nxt;
  logic [6:0]  vga_y_nxt;
  logic [2:0]  vga_colour_nxt;
  logic        plot_nxt, busy_nxt, done_nxt;

  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  logic [4:0]  bit_idx;
  logic        last_px;

  assign last_px = (row == 3'd4) && (col == 3'd4);
  // One extra bit keeps the untruncated coordinate for clipping.
  assign sum_x   = {1'b0, cap_x} + 9'(col);
  assign sum_y   = {1'b0, cap_y} + 8'(row);
  assign bit_idx = 5'd24 - (5'(row) * 5'd5) - 5'(col);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRAW;
      DRAW:    if (last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    vga_x_nxt      = vga_x;
    vga_y_nxt      = vga_y;
    vga_colour_nxt = vga_colour;
    plot_nxt       = 1'b0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    case (state)
      DRAW: begin
        vga_x_nxt      = sum_x[7:0];
        vga_y_nxt      = sum_y[6:0];
        vga_colour_nxt = (!cap_erase && cap_sprite[bit_idx]) ? cap_colour : 3'b000;
        plot_nxt       = (32'(sum_x) < SCREEN_W) && (32'(sum_y) < SCREEN_H);
        busy_nxt       = 1'b1;
      end
      DONE: begin
        busy_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture registers, pixel counters and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_sprite <= '0;
      cap_x      <= '0;
      cap_y      <= '0;
      cap_colour <= '0;
      cap_erase  <= 1'b0;
      row        <= '0;
      col        <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_x      <= vga_x_nxt;
      vga_y      <= vga_y_nxt;
      vga_colour <= vga_colour_nxt;
      plot       <= plot_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      if (state == IDLE && start) begin
        cap_sprite <= sprite;
        cap_x      <= x_origin;
        cap_y      <= y_origin;
        cap_colour <= colour;
        cap_erase  <= erase;
        row        <= '0;
        col        <= '0;
      end else if (state == DRAW) begin
        if (col == 3'd4) begin
          col <= '0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

endmodule
